// File: rtl/dcache_wb2way.sv
// 2-way set-associative write-back data cache: 8 sets of 2-word blocks, LRU eviction, combinational hit.
// Misses refill through a single memory port; halt flushes dirty frames, stores the hit count, then raises flushed.
module dcache_wb2way #(
  parameter logic [31:0] CNT_ADDR = 32'h00003100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);
  typedef enum logic [3:0] {IDLE, WB0, WB1, LD0, LD1, FLUSH0, FLUSH1, CNT, DONE} state_t;

  state_t      state;
  logic [25:0] tag_q  [2][8];
  logic [31:0] word_q [2][8][2];
  logic [7:0]  valid_q [2];
  logic [7:0]  dirty_q [2];
  logic [7:0]  lru_q;
  logic [31:0] hit_cnt;
  logic [3:0]  frame;
  logic        victim;
  logic [25:0] miss_tag;
  logic [2:0]  miss_idx;

  logic [25:0] req_tag;
  logic [2:0]  req_idx;
  logic        req_word;
  logic        req;
  logic        hit0;
  logic        hit1;
  logic        hit;
  logic        hit_way;
  logic [2:0]  fset;
  logic        fway;
  logic        fdirty;
  logic        second;
  logic        addr_unused;

  assign req_tag     = dmemaddr[31:6];
  assign req_idx     = dmemaddr[5:3];
  assign req_word    = dmemaddr[2];
  assign addr_unused = ^dmemaddr[1:0];

  // Requests are only looked up in IDLE and never while halted.
  assign req      = (dmemREN | dmemWEN) & ~halt & (state == IDLE);
  assign hit0     = valid_q[0][req_idx] & (tag_q[0][req_idx] == req_tag);
  assign hit1     = valid_q[1][req_idx] & (tag_q[1][req_idx] == req_tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign dhit     = req & hit;
  assign dmemload = (dhit & ~dmemWEN) ? word_q[hit_way][req_idx][req_word] : '0;
  assign flushed  = (state == DONE);

  assign fset   = frame[3:1];
  assign fway   = frame[0];
  assign fdirty = valid_q[fway][fset] & dirty_q[fway][fset];
  assign second = (state == WB1) || (state == LD1) || (state == FLUSH1);

  always_comb begin
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = '0;
    dstore = '0;
    case (state)
      WB0, WB1: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[victim][miss_idx], miss_idx, second, 2'b00};
        dstore = word_q[victim][miss_idx][second];
      end
      LD0, LD1: begin
        dREN  = 1'b1;
        daddr = {miss_tag, miss_idx, second, 2'b00};
      end
      FLUSH0, FLUSH1: begin
        if (fdirty) begin
          dWEN   = 1'b1;
          daddr  = {tag_q[fway][fset], fset, second, 2'b00};
          dstore = word_q[fway][fset][second];
        end
      end
      CNT: begin
        dWEN   = 1'b1;
        daddr  = CNT_ADDR;
        dstore = hit_cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
      hit_cnt    <= '0;
      frame      <= '0;
      victim     <= 1'b0;
      miss_tag   <= '0;
      miss_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (halt) begin
            frame <= '0;
            state <= FLUSH0;
          end else if (req) begin
            if (hit) begin
              lru_q[req_idx] <= ~hit_way;
              hit_cnt        <= hit_cnt + 32'd1;
              if (dmemWEN) dirty_q[hit_way][req_idx] <= 1'b1;
            end else begin
              // The refilled request hits afterwards, so the miss itself nets to zero.
              victim   <= lru_q[req_idx];
              miss_tag <= req_tag;
              miss_idx <= req_idx;
              hit_cnt  <= hit_cnt - 32'd1;
              if (valid_q[lru_q[req_idx]][req_idx] && dirty_q[lru_q[req_idx]][req_idx])
                state <= WB0;
              else
                state <= LD0;
            end
          end
        end
        WB0: if (!dwait) state <= WB1;
        WB1: if (!dwait) state <= LD0;
        LD0: if (!dwait) state <= LD1;
        LD1: begin
          if (!dwait) begin
            valid_q[victim][miss_idx] <= 1'b1;
            dirty_q[victim][miss_idx] <= 1'b0;
            state                     <= IDLE;
          end
        end
        FLUSH0, FLUSH1: begin
          if (state == FLUSH0 && fdirty) begin
            if (!dwait) state <= FLUSH1;
          end else if (state == FLUSH0 || !dwait) begin
            if (frame == 4'd15) begin
              state <= CNT;
            end else begin
              frame <= frame + 4'd1;
              state <= FLUSH0;
            end
          end
        end
        CNT: if (!dwait) state <= DONE;
        default: state <= DONE;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked separately.
  always_ff @(posedge CLK) begin
    if (dhit && dmemWEN) word_q[hit_way][req_idx][req_word] <= dmemstore;
    if ((state == LD0 || state == LD1) && !dwait) word_q[victim][miss_idx][second] <= dload;
    if (state == LD1 && !dwait) tag_q[victim][miss_idx] <= miss_tag;
  end

endmodule

// File: tb/tb_dcache_wb2way.sv
// Bench for dcache_wb2way: request vector table, memory model with wait states,
// and a queue of expected memory transfers compared as each transfer completes.
module tb_dcache_wb2way;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        halt;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        miss;
    logic        wb;
    logic [31:0] wb_base;
    logic [31:0] wb_d0;
    logic [31:0] wb_d1;
    logic [31:0] load;
  } vec_t;

  txn_t        sb_q[$];
  logic [31:0] mem [logic [31:0]];
  int          wcnt = 0;
  int          wait_cycles = 2;

  dcache_wb2way dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  task automatic push_rd(input logic [31:0] a);
    txn_t t;
    t.we = 1'b0; t.addr = a; t.data = '0;
    sb_q.push_back(t);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = 1'b1; t.addr = a; t.data = d;
    sb_q.push_back(t);
  endtask

  // Memory: each transfer sees wait_cycles busy cycles, then completes at the next rising edge.
  always @(negedge CLK) begin : mem_model
    txn_t t;
    if (nRST && (dREN || dWEN)) begin
      if (wcnt < wait_cycles) begin
        dwait = 1'b1;
        wcnt++;
      end else begin
        dwait = 1'b0;
        wcnt  = 0;
        if (dWEN) mem[daddr] = dstore;
        else      dload = mem_rd(daddr);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: got we=%0d addr %h data %h, expected no transfer", dWEN, daddr, dstore);
        end else begin
          t = sb_q.pop_front();
          chk("txn_we", {31'b0, dWEN}, {31'b0, t.we});
          chk("txn_addr", daddr, t.addr);
          if (t.we) chk("txn_data", dstore, t.data);
        end
      end
    end else begin
      dwait = 1'b1;
      wcnt  = 0;
    end
  end

  task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] ld);
    dmemREN = r; dmemWEN = w; dmemaddr = a; dmemstore = d;
    lat = -1; ld = '0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (dhit) begin
        lat = c;
        ld  = dmemload;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  // A clean miss costs 1 lookup + 3 cycles per word; a dirty miss adds two write-back words.
  task automatic run_vec(input vec_t v, input int idx);
    int          lat;
    int          exp_lat;
    logic [31:0] ld;
    exp_lat = !v.miss ? 0 : (v.wb ? 13 : 7);
    if (v.wb) begin
      push_wr(v.wb_base, v.wb_d0);
      push_wr(v.wb_base + 32'd4, v.wb_d1);
    end
    if (v.miss) begin
      push_rd({v.addr[31:3], 3'b000});
      push_rd({v.addr[31:3], 3'b100});
    end
    do_req(v.ren, v.wen, v.addr, v.wdata, lat, ld);
    chk($sformatf("vec%0d_latency", idx), lat, exp_lat);
    if (v.ren && !v.wen) chk($sformatf("vec%0d_load", idx), ld, v.load);
  endtask

  task automatic do_reset();
    nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic do_flush(input string tag);
    bit done;
    dmemREN = 1'b1; dmemWEN = 1'b0; dmemaddr = 32'h100; halt = 1'b1;
    #1;
    chk({tag, "_halt_dhit"}, {31'b0, dhit}, 32'd0);
    @(negedge CLK);
    dmemREN = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      #1;
      if (flushed) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_flushed"}, {31'b0, done}, 32'd1);
    dmemREN = 1'b1; halt = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk({tag, "_flushed_held"}, {31'b0, flushed}, 32'd1);
    chk({tag, "_done_dhit"}, {31'b0, dhit}, 32'd0);
    chk({tag, "_done_strobes"}, {30'b0, dREN, dWEN}, 32'd0);
    dmemREN = 1'b0;
    chk({tag, "_sb_empty"}, sb_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[11];
    vec_t v;
    bit   found;

    nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    dmemaddr = '0; dmemstore = '0; dwait = 1'b1; dload = '0;
    mem[32'h100] = 32'hAAAA; mem[32'h104] = 32'hBBBB;
    mem[32'h140] = 32'h1400; mem[32'h144] = 32'h1440;
    mem[32'h180] = 32'h1800; mem[32'h184] = 32'h1840;
    mem[32'h1C0] = 32'h1C00; mem[32'h1C4] = 32'h1C40;
    mem[32'h208] = 32'h2080; mem[32'h20C] = 32'h20C0;
    mem[32'h300] = 32'h3000; mem[32'h304] = 32'h3040;
    mem[32'h110] = 32'h1100; mem[32'h114] = 32'h1140;

    //          ren   wen   addr        wdata        miss  wb    wb_base     wb_d0        wb_d1        load
    tbl[0]  = '{1'b1, 1'b0, 32'h100, 32'h0,     1'b1, 1'b0, 32'h0,   32'h0,    32'h0,    32'hAAAA};
    tbl[1]  = '{1'b1, 1'b0, 32'h104, 32'h0,     1'b0, 1'b0, 32'h0,   32'h0,    32'h0,    32'hBBBB};
    tbl[2]  = '{1'b0, 1'b1, 32'h100, 32'h1234,  1'b0, 1'b0, 32'h0,   32'h0,    32'h0,    32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h100, 32'h0,     1'b0, 1'b0, 32'h0,   32'h0,    32'h0,    32'h1234};
    tbl[4]  = '{1'b1, 1'b0, 32'h140, 32'h0,     1'b1, 1'b0, 32'h0,   32'h0,    32'h0,    32'h1400};
    tbl[5]  = '{1'b1, 1'b0, 32'h180, 32'h0,     1'b1, 1'b1, 32'h100, 32'h1234, 32'hBBBB, 32'h1800};
    tbl[6]  = '{1'b1, 1'b0, 32'h1C0, 32'h0,     1'b1, 1'b0, 32'h0,   32'h0,    32'h0,    32'h1C00};
    tbl[7]  = '{1'b1, 1'b0, 32'h180, 32'h0,     1'b0, 1'b0, 32'h0,   32'h0,    32'h0,    32'h1800};
    tbl[8]  = '{1'b1, 1'b1, 32'h20C, 32'h5555,  1'b1, 1'b0, 32'h0,   32'h0,    32'h0,    32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h20C, 32'h0,     1'b0, 1'b0, 32'h0,   32'h0,    32'h0,    32'h5555};
    tbl[10] = '{1'b1, 1'b0, 32'h184, 32'h0,     1'b0, 1'b0, 32'h0,   32'h0,    32'h0,    32'h1840};

    repeat (2) @(negedge CLK);
    #1;
    chk("rst_dhit", {31'b0, dhit}, 32'd0);
    chk("rst_dmemload", dmemload, 32'd0);
    chk("rst_flushed", {31'b0, flushed}, 32'd0);
    chk("rst_strobes", {30'b0, dREN, dWEN}, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_dstore", dstore, 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 11; i++) run_vec(tbl[i], i);
    chk("tableA_sb_empty", sb_q.size(), 32'd0);

    // Reset while the second refill word is outstanding.
    push_rd(32'h300);
    dmemREN = 1'b1; dmemaddr = 32'h300;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      #1;
      if (dREN && daddr == 32'h304) begin
        found = 1'b1;
        break;
      end
    end
    chk("ld1_reached", {31'b0, found}, 32'd1);
    nRST = 1'b0;
    dmemREN = 1'b0;
    #1;
    chk("midrst_strobes", {30'b0, dREN, dWEN}, 32'd0);
    chk("midrst_daddr", daddr, 32'd0);
    chk("midrst_dhit", {31'b0, dhit}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("midrst_sb_empty", sb_q.size(), 32'd0);
    v = '{1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h3000};
    run_vec(v, 20);
    v = '{1'b1, 1'b0, 32'h180, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1800};
    run_vec(v, 21);

    // Two dirty blocks (frames 0 and 4), three true hits, then flush.
    do_reset();
    @(negedge CLK);
    v = '{1'b0, 1'b1, 32'h100, 32'h11,   1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    run_vec(v, 30);
    v = '{1'b0, 1'b1, 32'h114, 32'h22,   1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    run_vec(v, 31);
    v = '{1'b1, 1'b0, 32'h100, 32'h0,    1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h11};
    run_vec(v, 32);
    v = '{1'b0, 1'b1, 32'h104, 32'h33,   1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    run_vec(v, 33);
    v = '{1'b1, 1'b0, 32'h110, 32'h0,    1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1100};
    run_vec(v, 34);
    push_wr(32'h100, 32'h11);
    push_wr(32'h104, 32'h33);
    push_wr(32'h110, 32'h1100);
    push_wr(32'h114, 32'h22);
    push_wr(32'h3100, 32'd3);
    do_flush("flushB");

    // Hit counter wraps from all-ones to zero.
    do_reset();
    @(negedge CLK);
    v = '{1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h11};
    run_vec(v, 40);
    force dut.hit_cnt = 32'hFFFF_FFFF;
    @(negedge CLK);
    release dut.hit_cnt;
    v = '{1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h33};
    run_vec(v, 41);
    push_wr(32'h3100, 32'h0);
    do_flush("flushC");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
